prio_event_encoder8x3: RTL
==========================

# prio_event_encoder8x3

Sequential 8-to-3 priority encoder with a registered valid/ready output, the encode-side counterpart of the team's 3-to-8 one-hot decoder. It collects single-cycle or level event requests on 8 lines into a sticky pending register. It presents the highest-index pending line as a 3-bit binary code and holds each code stable until the consumer accepts it. Typical use: an event/interrupt source feeding a block that drives a 3x8 decoder from the accepted code.

## Interface
- No parameters; widths fixed at 8 request lines / 3-bit code.
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `en`  input  1  capture enable; when 0, `req` is ignored.
- `clr`  input  1  synchronous flush of pending state and output.
- `req`  input  8  event request lines, sampled every edge.
- `out_ready`  input  1  consumer accepts `code` when high with `valid`.
- `code`  output  3  binary index of the line being presented.
- `valid`  output  1  `code` is meaningful.
- `pend`  output  8  registered pending bitmap (in-flight bit included).
- `dup_err`  output  1  one-cycle pulse: request hit an already-pending line.

## Operation
- Reset (`rst_n`=0, asynchronous): `pend`=8'h00, `code`=3'd0, `valid`=0, `dup_err`=0.
- Handshake ("accept") occurs at an edge where `valid`=1 and `out_ready`=1.
- `clr`=1 at an edge overrides everything:
  - `pend`=0, `valid`=0, `code`=0, `dup_err`=0.
  - `req` is not captured on that edge.
- Pending update, when `clr`=0:
  - `pend` <= (`pend` & ~M) | (`en` ? `req` : 0).
  - M = one-hot(`code`) on an accept edge, else 0.
- Request arriving on the served line at its accept edge: bit stays set, becomes a new event, no `dup_err`.
- `dup_err`, registered: 1 for the cycle after an edge where, for some i:
  - `en`=1, `req[i]`=1, `pend[i]`=1,
  - and i is not the line being accepted at that edge.
- Output state machine, two states:
  - IDLE (`valid`=0): if `pend`!=0, load `code`=highest set index of `pend`, go to HOLD. `req` on the same edge is not considered.
  - HOLD (`valid`=1):
    - No accept: `code` held, no preemption even if a higher line becomes pending.
    - Accept: let P = `pend` & ~one-hot(`code`). If P!=0, load highest index of P and stay in HOLD (back-to-back). Else go to IDLE.
- Priority: index 7 highest, 0 lowest.
- Invariant: while `valid`=1, `pend[code]`=1.
- `en`=0 does not stall the output side; pending lines keep draining.

## Timing
- Request latency:
  - `req[i]` high at edge N sets `pend[i]` after edge N.
  - With output IDLE, `valid`/`code` appear after edge N+1 (2 edges total).
- Throughput: one code per cycle while `out_ready`=1 and lines remain pending.
- Outputs are fully registered; no combinational path from inputs to outputs.
- Reset deassertion: first capture at the first rising edge with `rst_n`=1.
- Reset mid-HOLD: the in-flight code is discarded; nothing is re-presented.

## Test plan
- Reset, then single event:
  - Stimulus: `rst_n` low then high; `req`=8'h10 for 1 cycle, `out_ready`=1.
  - Response: all outputs 0 after reset. `pend`=8'h10 after edge 1. `valid`=1, `code`=4 after edge 2. `valid`=0, `pend`=0 after edge 3.
- Priority drain with back-to-back accepts:
  - Stimulus: `req`=8'hA5 one cycle, `out_ready`=1.
  - Response: codes 7,5,2,0 on 4 consecutive cycles, then `valid`=0.
- Hold with no preemption:
  - Stimulus: `req`=8'h02, `out_ready`=0; after `valid`, `req`=8'h80 one cycle; 3 cycles later `out_ready`=1.
  - Response: `code`=1 held throughout, then `code`=7, then idle.
- Duplicate and re-arm:
  - Stimulus: `req`=8'h08 twice while bit 3 is pending but not being accepted.
  - Response: `dup_err` pulses once.
  - Stimulus: `req[3]` high exactly on the accept edge of code 3.
  - Response: code 3 is re-presented, no `dup_err`.
- Enable and clear:
  - Stimulus: `en`=0 with `req`=8'hFF.
  - Response: `pend` unchanged.
  - Stimulus: `clr`=1 while in HOLD with `pend`=8'h0C.
  - Response: `pend`=0, `valid`=0 next cycle; `req` on that edge is dropped.
- Asynchronous reset mid-HOLD:
  - Stimulus: `rst_n` low between edges while `valid`=1.
  - Response: outputs go to 0 immediately, without waiting for an edge.

Source files
------------

// File: rtl/prio_event_encoder8x3.sv
// Sequential 8-to-3 priority encoder: sticky pending bitmap of event lines,
// highest pending index presented on a registered valid/ready output.
module prio_event_encoder8x3 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic [7:0] req,
  input  logic       out_ready,
  output logic [2:0] code,
  output logic       valid,
  output logic [7:0] pend,
  output logic       dup_err
);

  // Handshake: a code transfers at a rising edge where valid and out_ready
  // are both high; code stays stable while valid is high and not accepted.
  typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_code;
  logic [2:0]  w_code_nxt;
  logic [7:0]  r_pend;
  logic        r_dup;

  logic        w_accept;
  logic [7:0]  w_mask;
  logic [7:0]  w_req_eff;
  logic [7:0]  w_pend_nxt;
  logic [7:0]  w_rest;
  logic        w_dup;

  function automatic logic [2:0] f_highest(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  assign w_accept   = (r_state == S_HOLD) && out_ready;
  assign w_mask     = w_accept ? (8'd1 << r_code) : 8'd0;
  assign w_req_eff  = en ? req : 8'd0;
  assign w_pend_nxt = (r_pend & ~w_mask) | w_req_eff;
  // The line being retired may be re-requested on its accept edge without error.
  assign w_dup      = |(w_req_eff & r_pend & ~w_mask);
  // Lines still pending after the served one retires; same-edge requests excluded.
  assign w_rest     = r_pend & ~w_mask;

  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    case (r_state)
      S_IDLE: begin
        if (r_pend != 8'd0) begin
          w_code_nxt  = f_highest(r_pend);
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_accept) begin
          if (w_rest != 8'd0) begin
            w_code_nxt = f_highest(w_rest);
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_code  <= 3'd0;
      r_pend  <= 8'd0;
      r_dup   <= 1'b0;
    end else if (clr) begin
      r_state <= S_IDLE;
      r_code  <= 3'd0;
      r_pend  <= 8'd0;
      r_dup   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_code  <= w_code_nxt;
      r_pend  <= w_pend_nxt;
      r_dup   <= w_dup;
    end
  end

  assign code    = r_code;
  assign valid   = (r_state == S_HOLD);
  assign pend    = r_pend;
  assign dup_err = r_dup;

endmodule
